// File: rtl/fir_pkg.sv
// fir_pkg: register map, default read value and read-FSM state shared by the collector.
package fir_pkg;
    localparam int REG_CTRL = 'h00;
    localparam int REG_LEVEL = 'h04;
    localparam int REG_COUNT = 'h08;
    localparam int REG_CHECKSUM = 'h0C;
    localparam int REG_POP = 'h10;
    localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/fir_stream_collector_if.sv
// fir_stream_collector_if: AXI-Stream sink port plus AXI-Lite register window.
interface fir_stream_collector_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic ss_tvalid, ss_tlast, ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic awvalid, awready, wvalid, wready;
    logic [pADDR_WIDTH-1:0] awaddr, araddr;
    logic [pDATA_WIDTH-1:0] wdata, rdata;
    logic arvalid, arready, rvalid, rready;
    modport master (
        output ss_tvalid, ss_tdata, ss_tlast, input ss_tready,
        output awvalid, awaddr, wvalid, wdata, input awready, wready,
        output arvalid, araddr, rready, input arready, rvalid, rdata
    );
    modport slave (
        input ss_tvalid, ss_tdata, ss_tlast, output ss_tready,
        input awvalid, awaddr, wvalid, wdata, output awready, wready,
        input arvalid, araddr, rready, output arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: synchronous FIFO with combinational head and occupancy counter.
module fir_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic wr, rd;
    assign wr = push & !full;
    assign rd = pop & !empty;
    assign full = level == (AW + 1)'(DEPTH);
    assign empty = level == '0;
    assign dout = mem[rptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end
endmodule

// File: rtl/fir_stream_collector.sv
// fir_stream_collector: buffers FIR output samples, tracks count/checksum/end-of-frame,
// and exposes results and status through an AXI-Lite register window.
module fir_stream_collector
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst,
    fir_stream_collector_if.slave bus,
    output logic                  frame_done
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic [pDATA_WIDTH-1:0] head, rd_val, status;
    logic [LW-1:0] level;
    logic [31:0] count, checksum;
    logic full, empty, halt, ovf, wr_ctrl, clear_now, accept, pop, unused_wdata;
    rd_state_t state, state_nxt;

    function automatic logic hit(input logic [pADDR_WIDTH-1:0] a, input int off);
        return a == pADDR_WIDTH'(off);
    endfunction

    assign bus.awready = bus.awvalid & bus.wvalid;
    assign bus.wready = bus.awvalid & bus.wvalid;
    assign wr_ctrl = bus.awvalid & bus.wvalid & hit(bus.awaddr, REG_CTRL);
    assign clear_now = wr_ctrl & bus.wdata[0];
    assign unused_wdata = &{1'b0, bus.wdata[pDATA_WIDTH-1:2]};
    assign bus.ss_tready = !full & !halt & !clear_now;
    assign accept = bus.ss_tvalid & bus.ss_tready;
    // A clear landing with the AR still returns pre-clear data but must not pop.
    assign pop = (state == R_IDLE) & bus.arvalid & hit(bus.araddr, REG_POP) & !empty & !clear_now;

    fir_sync_fifo #(.WIDTH(pDATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(axis_clk), .rst(axis_rst), .push(accept), .pop(pop), .flush(clear_now),
        .din(bus.ss_tdata), .dout(head), .level(level), .full(full), .empty(empty)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_rst || clear_now) begin
            count <= '0;
            checksum <= '0;
            frame_done <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (accept) count <= count + 1'b1;
            if (accept) checksum <= checksum + 32'(bus.ss_tdata);
            if (accept && bus.ss_tlast) frame_done <= 1'b1;
            if (bus.ss_tvalid && full && !halt) ovf <= 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) halt <= 1'b0;
        else if (wr_ctrl) halt <= bus.wdata[1];
    end

    assign status = pDATA_WIDTH'({halt, ovf, frame_done, full, empty});
    assign rd_val = hit(bus.araddr, REG_CTRL)     ? status :
                    hit(bus.araddr, REG_LEVEL)    ? pDATA_WIDTH'(level) :
                    hit(bus.araddr, REG_COUNT)    ? pDATA_WIDTH'(count) :
                    hit(bus.araddr, REG_CHECKSUM) ? pDATA_WIDTH'(checksum) :
                    hit(bus.araddr, REG_POP) && !empty ? head :
                    pDATA_WIDTH'(RD_DEFAULT);

    always_ff @(posedge axis_clk) begin
        state <= axis_rst ? R_IDLE : state_nxt;
    end

    always_comb begin
        state_nxt = (state == R_IDLE) ? (bus.arvalid ? R_DATA : R_IDLE)
                                      : (bus.rready ? R_IDLE : R_DATA);
    end

    always_comb begin
        bus.arready = state == R_IDLE;
        bus.rvalid = state == R_DATA;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) bus.rdata <= '0;
        else if (state == R_IDLE && bus.arvalid) bus.rdata <= rd_val;
    end
endmodule
